alu_issue_arbiter: RTL and testbench

//  Shares the single 16-bit registered ALU between two requesters (0 = decode/execute

---
 rtl/alu_issue_arbiter_if.sv | 29 ++
 rtl/alu_issue_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_issue_arbiter.
// master = requester side, slave = arbiter side.
interface alu_issue_arbiter_if #(
    parameter int unsigned WIDTH = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [2:0]       req_op0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [2:0]       req_op1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Shares one registered ALU between two requesters: arbitrate, hold operands, return result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_issue_arbiter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    alu_issue_arbiter_if.slave bus,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);
    localparam int unsigned CNT_W = $clog2(ALU_LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rsp_id;
    logic [1:0]       rsp_valid;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;

    logic [1:0]       grant;
    logic             accept;
    logic             acc_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (bus.req_valid[0]) begin
            grant = 2'b01;
        end else if (bus.req_valid[1]) begin
            grant = 2'b10;
        end
    end
`else
    logic last_grant;

    // Ties go to whichever requester was not served last.
    always_comb begin
        grant = 2'b00;
        case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= acc_id;
        end
    end
`endif

    assign bus.req_ready = (state == IDLE) ? grant : 2'b00;
    assign accept        = |bus.req_ready;
    assign acc_id        = grant[1];
    assign sel_a         = acc_id ? bus.req_a1  : bus.req_a0;
    assign sel_b         = acc_id ? bus.req_b1  : bus.req_b0;
    assign sel_op        = acc_id ? bus.req_op1 : bus.req_op0;

    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_zero   = rsp_zero;
    assign bus.rsp_err    = rsp_err;

    // ALU operand registers double as the latched request; they only move on a legal accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rsp_id     <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            alu_input1 <= '0;
            alu_input2 <= '0;
            alu_ctrl   <= 3'b000;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_id <= acc_id;
                        busy   <= 1'b1;
                        if (op_legal(sel_op)) begin
                            alu_input1 <= sel_a;
                            alu_input2 <= sel_b;
                            alu_ctrl   <= sel_op;
                            cnt        <= CNT_W'(ALU_LATENCY);
                            state      <= EXEC;
                        end else begin
                            rsp_result <= '0;
                            rsp_zero   <= 1'b0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= grant;
                            state      <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_result <= alu_result;
                        rsp_zero   <= alu_zero;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= rsp_id ? 2'b10 : 2'b01;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[rsp_id]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a registered ALU model and an expected-response queue.
// Honours ALU_ARB_FIXED_PRIO_EN for the tie-break expectation.
module tb_alu_issue_arbiter;
    localparam int ALU_LAT = 1;

    typedef struct {
        logic [1:0]  valid;
        logic [15:0] result;
        logic        zero;
        logic        err;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] alu_input1;
    logic [15:0] alu_input2;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        busy;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic tb_last = 1'b1;

    alu_issue_arbiter_if #(.WIDTH(16)) bus ();

    alu_issue_arbiter #(.WIDTH(16), .ALU_LATENCY(ALU_LAT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .alu_input1 (alu_input1),
        .alu_input2 (alu_input2),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
        case (op)
            3'b000:  alu_f = a & b;
            3'b001:  alu_f = a | b;
            3'b010:  alu_f = a + b;
            3'b110:  alu_f = a - b;
            3'b111:  alu_f = {15'd0, (a < b)};
            default: alu_f = 16'hdead;
        endcase
    endfunction

    function automatic logic op_ok(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
               (op == 3'b110) || (op == 3'b111);
    endfunction

    // Single-cycle registered ALU sitting behind the arbiter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_result <= 16'h0;
            alu_zero   <= 1'b0;
        end else begin
            alu_result <= alu_f(alu_input1, alu_input2, alu_ctrl);
            alu_zero   <= (alu_f(alu_input1, alu_input2, alu_ctrl) == 16'h0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // lat = edges after the accept edge at which rsp_valid rises.
    function automatic void push_exp(input logic id, input logic [15:0] a, input logic [15:0] b,
                                     input logic [2:0] op);
        exp_t e;
        logic [15:0] r;
        r = alu_f(a, b, op);
        e.valid = id ? 2'b10 : 2'b01;
        if (op_ok(op)) begin
            e.result = r;
            e.zero   = (r == 16'h0);
            e.err    = 1'b0;
            e.lat    = ALU_LAT + 1;
        end else begin
            e.result = 16'h0;
            e.zero   = 1'b0;
            e.err    = 1'b1;
            e.lat    = 0;
        end
        sb.push_back(e);
    endfunction

    task automatic issue(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op);
        int n;
        @(negedge clock);
        if (id) begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op;
        end else begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
        end
        bus.req_valid[id] = 1'b1;
        n = 0;
        #1;
        while (bus.req_ready === 2'b00 && n < 20) begin
            @(negedge clock); #1; n++;
        end
        chk("req_ready_grant", 32'(bus.req_ready), id ? 32'h2 : 32'h1);
        push_exp(id, a, b, op);
        @(posedge clock); #1;
        bus.req_valid[id] = 1'b0;
        tb_last = id;
    endtask

    task automatic get_rsp(input int stall);
        int n;
        exp_t e;
        logic [1:0] other;
        n = 0;
        while (bus.rsp_valid === 2'b00 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        chk("sb_size", 32'(sb.size()), 32'h1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        other = ~e.valid;
        chk("rsp_latency", 32'(n), 32'(e.lat));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.valid));
        chk("rsp_result", 32'(bus.rsp_result), 32'(e.result));
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        chk("busy_resp", 32'(busy), 32'h1);
        if (stall > 0) begin
            @(negedge clock);
            bus.rsp_ready = other;
            bus.req_valid = bus.req_valid | other;
            for (int i = 0; i < stall; i++) begin
                @(posedge clock); #1;
                chk("stall_valid", 32'(bus.rsp_valid), 32'(e.valid));
                chk("stall_result", 32'(bus.rsp_result), 32'(e.result));
                chk("stall_no_accept", 32'(bus.req_ready), 32'h0);
            end
            @(negedge clock);
            bus.req_valid = bus.req_valid & ~other;
        end else begin
            @(negedge clock);
        end
        bus.rsp_ready = e.valid;
        @(posedge clock); #1;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'h0);
        bus.rsp_ready = 2'b00;
    endtask

    initial begin
        logic [1:0] exp_g;
        logic       g;
        int         n;

        bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
        bus.req_a0 = 16'h0; bus.req_b0 = 16'h0; bus.req_op0 = 3'b000;
        bus.req_a1 = 16'h0; bus.req_b1 = 16'h0; bus.req_op1 = 3'b000;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'h0);
        chk("rst_alu_in1", 32'(alu_input1), 32'h0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;

        // Requester 0 ADD
        issue(1'b0, 16'h0003, 16'h0004, 3'b010);
        chk("exec_busy", 32'(busy), 32'h1);
        get_rsp(0);
        chk("alu_hold_in1", 32'(alu_input1), 32'h3);
        chk("alu_hold_ctrl", 32'(alu_ctrl), 32'h2);

        // Illegal opcode: immediate error response, ALU untouched
        issue(1'b0, 16'h5555, 16'h0001, 3'b011);
        get_rsp(0);
        chk("illegal_ctrl_hold", 32'(alu_ctrl), 32'h2);
        chk("illegal_in1_hold", 32'(alu_input1), 32'h3);

        // Requester 1 SUB equal operands, response held off for 5 cycles
        issue(1'b1, 16'h1234, 16'h1234, 3'b110);
        get_rsp(5);

        // Both requesters valid continuously
        @(negedge clock);
        bus.req_a0 = 16'h00ff; bus.req_b0 = 16'h0001; bus.req_op0 = 3'b010;
        bus.req_a1 = 16'h0005; bus.req_b1 = 16'h9000; bus.req_op1 = 3'b111;
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (bus.req_ready === 2'b00 && n < 20) begin
                @(negedge clock); #1; n++;
            end
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = tb_last ? 2'b01 : 2'b10;
`endif
            chk("tie_grant", 32'(bus.req_ready), 32'(exp_g));
            g = exp_g[1];
            if (g) push_exp(g, bus.req_a1, bus.req_b1, bus.req_op1);
            else   push_exp(g, bus.req_a0, bus.req_b0, bus.req_op0);
            @(posedge clock); #1;
            tb_last = g;
            get_rsp(0);
        end
        @(negedge clock);
        bus.req_valid = 2'b00;

        // Reset during EXEC abandons the operation
        issue(1'b0, 16'h0010, 16'h0020, 3'b010);
        reset_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("midrst_rsp_result", 32'(bus.rsp_result), 32'h0);
        chk("midrst_alu_in1", 32'(alu_input1), 32'h0);
        chk("midrst_alu_in2", 32'(alu_input2), 32'h0);
        chk("midrst_alu_ctrl", 32'(alu_ctrl), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        @(negedge clock);
        bus.req_valid = 2'b11;
        #1;
        chk("post_rst_tie_req0", 32'(bus.req_ready), 32'h1);
        @(negedge clock);
        bus.req_valid = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
